// File: rtl/inta_responder.sv
// 8086-mode interrupt-acknowledge responder: IRR/ISR bookkeeping, fixed priority
// (IR0 highest), INT generation and two-pulse INTA vector delivery.
//
// state | meaning
// IDLE  | tracking requests, int_out follows req_ok
// ACK1  | first INTA seen, level committed, waiting for second falling edge
// ACK2  | vector driven on the bus until INTA rises
module inta_responder #(
    parameter int VEC_W    = 8,
    parameter int SPUR_LVL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ir_req,
    input  logic [7:0]       imr,
    input  logic [4:0]       vec_base,
    input  logic             aeoi,
    input  logic             eoi,
    input  logic             inta_n,
    output logic             int_out,
    output logic [VEC_W-1:0] data_out,
    output logic             data_oe,
    output logic [7:0]       irr,
    output logic [7:0]       isr
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    localparam logic [2:0] SPUR_SEL = 3'(SPUR_LVL);

    state_t     state;
    logic       inta_q;
    logic [2:0] sel;
    logic       spur;

    logic       fall;
    logic       rise;
    logic [7:0] pend;
    logic [2:0] win;
    logic [3:0] top_isr;
    logic       req_ok;
    logic [7:0] isr_next;

    assign fall   = inta_q & ~inta_n;
    assign rise   = ~inta_q & inta_n;
    assign pend   = irr & ~imr;
    assign req_ok = (pend != 8'd0) && ({1'b0, win} < top_isr);

    always_comb begin
        win     = 3'd0;
        top_isr = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) win = 3'(i);
            if (isr[i])  top_isr = 4'(i);
        end
    end

    // EOI works on the pre-existing top_isr; the first-INTA set is applied
    // last so a newly committed level survives a coincident EOI.
    always_comb begin
        isr_next = isr;
        if (eoi && top_isr != 4'd8)
            isr_next[top_isr[2:0]] = 1'b0;
        if (state == ACK2 && rise && aeoi && !spur)
            isr_next[sel] = 1'b0;
        if (state == IDLE && fall && pend != 8'd0)
            isr_next[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inta_q   <= 1'b1;
            sel      <= 3'd0;
            spur     <= 1'b0;
            irr      <= 8'd0;
            isr      <= 8'd0;
            int_out  <= 1'b0;
            data_out <= '0;
            data_oe  <= 1'b0;
        end else begin
            inta_q <= inta_n;
            isr    <= isr_next;
            case (state)
                IDLE: begin
                    irr     <= ir_req;
                    int_out <= req_ok;
                    if (fall) begin
                        state   <= ACK1;
                        int_out <= 1'b0;
                        if (pend != 8'd0) begin
                            sel      <= win;
                            spur     <= 1'b0;
                            irr[win] <= 1'b0;
                        end else begin
                            sel  <= SPUR_SEL;
                            spur <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    int_out <= 1'b0;
                    // A falling edge here implies INTA already went high again.
                    if (fall) begin
                        data_out <= {vec_base, sel};
                        data_oe  <= 1'b1;
                        state    <= ACK2;
                    end
                end
                ACK2: begin
                    int_out <= 1'b0;
                    if (rise) begin
                        data_oe <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inta_responder.sv
// Directed bench for inta_responder: priority, nesting, EOI, spurious, AEOI,
// masking and asynchronous abort.
module tb_inta_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] ir_req;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       aeoi;
    logic       eoi;
    logic       inta_n;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] irr;
    logic [7:0] isr;

    int tests;
    int fails;

    inta_responder #(.VEC_W(8), .SPUR_LVL(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_req   (ir_req),
        .imr      (imr),
        .vec_base (vec_base),
        .aeoi     (aeoi),
        .eoi      (eoi),
        .inta_n   (inta_n),
        .int_out  (int_out),
        .data_out (data_out),
        .data_oe  (data_oe),
        .irr      (irr),
        .isr      (isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full two-pulse acknowledge; optional eoi strobe coincides with the first falling edge.
    task automatic inta_seq(input logic eoi_first,
                            output logic [7:0] isr_a, output logic int_a,
                            output logic oe_a, output logic [7:0] vec_a,
                            output logic oe_end, output logic [7:0] isr_end);
        inta_n = 1'b0;
        eoi    = eoi_first;
        @(negedge clk);
        eoi   = 1'b0;
        isr_a = isr;
        int_a = int_out;
        @(negedge clk);
        inta_n = 1'b1;
        tick(2);
        inta_n = 1'b0;
        @(negedge clk);
        oe_a  = data_oe;
        vec_a = data_out;
        @(negedge clk);
        inta_n = 1'b1;
        @(negedge clk);
        oe_end  = data_oe;
        isr_end = isr;
    endtask

    task automatic test_reset;
        tick(2);
        tests++;
        if ({int_out, data_oe, data_out, irr, isr} !== 26'd0) begin
            fails++;
            $display("FAIL reset: got int=%b oe=%b dout=%h irr=%h isr=%h, need all 0",
                     int_out, data_oe, data_out, irr, isr);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_basic;
        logic [7:0] isr_a, vec_a, isr_end;
        logic int_a, oe_a, oe_end;
        ir_req = 8'h24;
        tick(3);
        tests++;
        if (int_out !== 1'b1 || irr !== 8'h24) begin
            fails++;
            $display("FAIL basic_int: got int=%b irr=%h, need 1/24", int_out, irr);
        end
        inta_seq(1'b0, isr_a, int_a, oe_a, vec_a, oe_end, isr_end);
        tests++;
        if (isr_a !== 8'h04 || int_a !== 1'b0) begin
            fails++;
            $display("FAIL basic_ack1: got isr=%h int=%b, need 04/0", isr_a, int_a);
        end
        tests++;
        if (oe_a !== 1'b1 || vec_a !== 8'h42) begin
            fails++;
            $display("FAIL basic_vec: got oe=%b vec=%h, need 1/42", oe_a, vec_a);
        end
        tests++;
        if (oe_end !== 1'b0 || data_out !== 8'h42 || isr_end !== 8'h04) begin
            fails++;
            $display("FAIL basic_end: got oe=%b dout=%h isr=%h, need 0/42/04",
                     oe_end, data_out, isr_end);
        end
    endtask

    task automatic test_nesting;
        logic [7:0] isr_a, vec_a, isr_end;
        logic int_a, oe_a, oe_end;
        ir_req = 8'h20;
        tick(3);
        tests++;
        if (int_out !== 1'b0) begin
            fails++;
            $display("FAIL nest_lower: got int=%b, need 0", int_out);
        end
        ir_req = 8'h22;
        tick(3);
        tests++;
        if (int_out !== 1'b1) begin
            fails++;
            $display("FAIL nest_higher: got int=%b, need 1", int_out);
        end
        inta_seq(1'b0, isr_a, int_a, oe_a, vec_a, oe_end, isr_end);
        tests++;
        if (isr_end !== 8'h06 || vec_a !== 8'h41 || oe_a !== 1'b1) begin
            fails++;
            $display("FAIL nest_seq: got isr=%h vec=%h oe=%b, need 06/41/1",
                     isr_end, vec_a, oe_a);
        end
    endtask

    task automatic test_eoi;
        ir_req = 8'h20;
        tick(2);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        tests++;
        if (isr !== 8'h04) begin
            fails++;
            $display("FAIL eoi_first: got isr=%h, need 04", isr);
        end
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        tick(1);
        tests++;
        if (isr !== 8'h00 || int_out !== 1'b1) begin
            fails++;
            $display("FAIL eoi_second: got isr=%h int=%b, need 00/1", isr, int_out);
        end
    endtask

    task automatic test_spurious;
        logic [7:0] isr_a, vec_a, isr_end;
        logic int_a, oe_a, oe_end;
        ir_req = 8'h08;
        tick(3);
        tests++;
        if (int_out !== 1'b1 || irr !== 8'h08) begin
            fails++;
            $display("FAIL spur_int: got int=%b irr=%h, need 1/08", int_out, irr);
        end
        ir_req = 8'h00;
        tick(1);
        inta_seq(1'b0, isr_a, int_a, oe_a, vec_a, oe_end, isr_end);
        tests++;
        if (isr_a !== 8'h00 || int_a !== 1'b0 || vec_a !== 8'h47 || isr_end !== 8'h00) begin
            fails++;
            $display("FAIL spur_seq: got isr=%h int=%b vec=%h isr_end=%h, need 00/0/47/00",
                     isr_a, int_a, vec_a, isr_end);
        end
    endtask

    task automatic test_aeoi_mask;
        logic [7:0] isr_a, vec_a, isr_end;
        logic int_a, oe_a, oe_end;
        aeoi   = 1'b1;
        ir_req = 8'h01;
        tick(3);
        inta_seq(1'b0, isr_a, int_a, oe_a, vec_a, oe_end, isr_end);
        tests++;
        if (isr_a !== 8'h01 || vec_a !== 8'h40 || isr_end !== 8'h00 || oe_end !== 1'b0) begin
            fails++;
            $display("FAIL aeoi_seq: got isr=%h vec=%h isr_end=%h oe=%b, need 01/40/00/0",
                     isr_a, vec_a, isr_end, oe_end);
        end
        imr = 8'h01;
        tick(3);
        tests++;
        if (int_out !== 1'b0 || irr !== 8'h01) begin
            fails++;
            $display("FAIL mask: got int=%b irr=%h, need 0/01", int_out, irr);
        end
        ir_req = 8'h00;
        imr    = 8'h00;
        aeoi   = 1'b0;
        tick(2);
    endtask

    task automatic test_eoi_collision;
        logic [7:0] isr_a, vec_a, isr_end;
        logic int_a, oe_a, oe_end;
        ir_req = 8'h04;
        tick(3);
        inta_seq(1'b0, isr_a, int_a, oe_a, vec_a, oe_end, isr_end);
        ir_req = 8'h02;
        tick(3);
        tests++;
        if (isr !== 8'h04 || int_out !== 1'b1) begin
            fails++;
            $display("FAIL coll_pre: got isr=%h int=%b, need 04/1", isr, int_out);
        end
        inta_seq(1'b1, isr_a, int_a, oe_a, vec_a, oe_end, isr_end);
        tests++;
        if (isr_a !== 8'h02 || isr_end !== 8'h02 || vec_a !== 8'h41) begin
            fails++;
            $display("FAIL coll_seq: got isr=%h isr_end=%h vec=%h, need 02/02/41",
                     isr_a, isr_end, vec_a);
        end
        ir_req = 8'h00;
        eoi    = 1'b1;
        tick(1);
        eoi = 1'b0;
        tick(1);
    endtask

    task automatic test_abort;
        ir_req = 8'h10;
        tick(3);
        inta_n = 1'b0;
        tick(1);
        inta_n = 1'b1;
        tick(2);
        inta_n = 1'b0;
        tick(1);
        tests++;
        if (data_oe !== 1'b1 || data_out !== 8'h44) begin
            fails++;
            $display("FAIL abort_pre: got oe=%b dout=%h, need 1/44", data_oe, data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (data_oe !== 1'b0 || isr !== 8'h00 || irr !== 8'h00 || int_out !== 1'b0) begin
            fails++;
            $display("FAIL abort_async: got oe=%b isr=%h irr=%h int=%b, need 0/00/00/0",
                     data_oe, isr, irr, int_out);
        end
        inta_n = 1'b1;
        ir_req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        tests++;
        if (data_oe !== 1'b0 || isr !== 8'h00 || int_out !== 1'b0) begin
            fails++;
            $display("FAIL abort_after: got oe=%b isr=%h int=%b, need 0/00/0",
                     data_oe, isr, int_out);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        ir_req   = 8'h00;
        imr      = 8'h00;
        vec_base = 5'b01000;
        aeoi     = 1'b0;
        eoi      = 1'b0;
        inta_n   = 1'b1;
        test_reset;
        test_basic;
        test_nesting;
        test_eoi;
        test_spurious;
        test_aeoi_mask;
        test_eoi_collision;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inta_responder.md
Name: inta_responder

Overview:
- PIC-side responder to the CPU interrupt-acknowledge protocol, using 8086-mode two-pulse INTA.
- Holds the IRR and ISR, resolves fixed priority (IR0 highest) and raises INT.
- On the first INTA pulse it commits the winning level to ISR; on the second it drives the vector onto the data bus.
- Sits between the request/mask logic and the data-bus buffer.

Parameters:
- VEC_W, 8, data bus / vector width. Fixed at 8; only 8 is supported.
- SPUR_LVL, 7, level number reported when a request disappears before the first INTA.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir_req  in  8  level-sensitive interrupt requests, already synchronised to clk.
- imr  in  8  mask register; 1 = level masked.
- vec_base  in  5  ICW2 T7..T3, upper vector bits.
- aeoi  in  1  automatic-EOI mode enable.
- eoi  in  1  one-cycle non-specific EOI strobe from OCW2 decode.
- inta_n  in  1  CPU acknowledge, active-low, synchronised to clk.
- int_out  out  1  interrupt request to the CPU.
- data_out  out  8  vector byte.
- data_oe  out  1  data bus drive enable.
- irr  out  8  interrupt request register.
- isr  out  8  in-service register.

Behaviour:
- Reset (async, rst_n=0): irr=0, isr=0, int_out=0, data_out=0, data_oe=0, state=IDLE, inta_q=1, sel=0.
- Edge detection:
  - inta_q registers inta_n each clk.
  - Falling edge = inta_q & ~inta_n.
  - Rising edge = ~inta_q & inta_n.
  - All actions take effect on the same clk edge that detects the edge (one-cycle latency from inta_n sampling).
- IRR: each clk, irr[i] <= ir_req[i], except while state is ACK1 or ACK2 (frozen during the acknowledge sequence). Masking does not clear irr.
- Priority:
  - pend = irr & ~imr.
  - win = lowest-index set bit of pend.
  - top_isr = lowest-index set bit of isr (8 = none).
  - req_ok = pend!=0 and win < top_isr.
- int_out: registered; int_out <= req_ok while state=IDLE; forced 0 from the first-INTA edge until the state returns to IDLE.
- FSM states: IDLE, ACK1, ACK2.
  - IDLE -> ACK1 on an INTA falling edge:
    - If pend!=0: sel<=win, isr[win]<=1, irr[win]<=0.
    - Else (spurious): sel<=SPUR_LVL, isr unchanged.
    - data_oe stays 0.
  - ACK1: wait for rising edge, then stay in ACK1 until the next falling edge.
  - ACK1 -> ACK2 on the second falling edge: data_out<={vec_base, sel[2:0]}, data_oe<=1.
  - ACK2 -> IDLE on the rising edge:
    - data_oe<=0; data_out holds its value.
    - If aeoi and the acknowledge was not spurious: isr[sel]<=0 on this edge.
- EOI:
  - eoi=1 clears the isr bit at top_isr; no effect if isr=0.
  - If eoi coincides with the AEOI clear on the same edge and both target the same bit, the bit clears once; if they target different bits, both clear.
  - An eoi coinciding with the first-INTA isr set applies to the pre-existing top_isr only; the newly set bit survives.
- Request-level changes:
  - Requests arriving during ACK1/ACK2 are captured once the state returns to IDLE.
  - The ir_req level must remain high for the IRR to stay set; dropping before the first INTA yields the spurious path.
- rst_n asserted mid-sequence aborts immediately: data_oe=0, state=IDLE, all registers cleared.
- An INTA falling edge while in ACK2 cannot occur (the rising edge is required first).
- The rising edge in ACK2 is taken before any new edge. No other states exist.

Test Plan:
1. Reset, then ir_req=8'h24, imr=0, vec_base=5'b01000, aeoi=0; two INTA pulses.
   - int_out=1 before the first pulse.
   - After the first falling edge: isr=8'h04, int_out=0.
   - Second pulse: data_oe=1, data_out=8'h42 while low; data_oe=0 after the rising edge.
2. Nesting: with isr=8'h04 held, raise ir_req bit 5 -> int_out stays 0. Raise bit 1 -> int_out=1; full INTA sequence -> isr=8'h06, vector 8'h41.
3. EOI:
   - eoi pulse with isr=8'h06 -> isr=8'h04.
   - Second eoi -> isr=0; int_out reasserts for pending bit 5 (imr=0).
4. Spurious: ir_req=8'h08 -> int_out=1; drop ir_req to 0 one cycle before the first INTA falling edge -> isr stays 0, second-pulse vector={vec_base,3'b111}.
5. AEOI and masking:
   - aeoi=1, ir_req=8'h01 -> after the second rising edge isr=0, vector=8'h40.
   - imr=8'h01 with ir_req=8'h01 -> int_out stays 0, irr=8'h01.
6. Reset mid-sequence: rst_n pulsed low during the second INTA low phase -> data_oe drops asynchronously, isr=irr=0, int_out=0, state=IDLE.
